pucch1_sym_ctrl: RTL and testbench

//  Sequences one PUCCH format 1 transmission symbol by symbol.
//  - Splits the PUCCH into hops and classifies each symbol as DMRS or data.
//  - Drives the external pucch1_spread instance (start/next, nSF, occi) once per hop.
//  - Emits a ready/valid stream of per-symbol descriptors to the resource-mapping stage.

---
 rtl/pucch1_sym_ctrl.sv | 167 ++++++++++++++++
 tb/tb_pucch1_sym_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pucch1_sym_ctrl.sv
// pucch1_sym_ctrl: sequences one PUCCH format 1 transmission symbol by symbol,
// driving the external spreader once per hop and streaming per-symbol descriptors.
// Optional configuration checking is enabled by defining PUCCH1_CTRL_CHECK_EN.
module pucch1_sym_ctrl #(
   parameter int SLOT_SYMS = 14,
   parameter int IDX_W     = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_start,
   input  logic [IDX_W-1:0] i_nsym,
   input  logic [IDX_W-1:0] i_start_sym,
   input  logic             i_hop_en,
   input  logic [2:0]       i_occi,
   output logic             o_spr_start,
   output logic             o_spr_next,
   output logic [2:0]       o_spr_nsf,
   output logic [2:0]       o_spr_occi,
   input  logic [3:0]       i_spr_phi,
   input  logic             i_spr_valid,
   output logic             o_sym_valid,
   input  logic             i_sym_ready,
   output logic [IDX_W-1:0] o_sym_idx,
   output logic             o_sym_dmrs,
   output logic             o_sym_hop,
   output logic [3:0]       o_sym_phi,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_err
);
   typedef enum logic [2:0] {IDLE, HOP_INIT, SPR_WAIT, EMIT, FIN} state_t;
   state_t           state_q, state_d;
   logic [IDX_W-1:0] n_q, n_d, s_q, s_d, k_q, k_d, end_q, end_d, k_inc;
   logic             hop_en_q, hop_en_d, hop_q, hop_d, have_q, have_d;
   logic             next_q, next_d, err_q, err_d, cfg_bad;
   logic [2:0]       occi_q, occi_d, nsf_q, nsf_d, left_q, left_d;
   logic [3:0]       phi_q, phi_d;

`ifdef PUCCH1_CTRL_CHECK_EN
   logic [IDX_W:0]   span;
   logic [IDX_W-1:0] min_nsf;
   // hop0 never carries more data than hop1, so its count is the minimum nSF
   assign span    = {1'b0, i_start_sym} + {1'b0, i_nsym};
   assign min_nsf = i_hop_en ? i_nsym >> 2 : i_nsym >> 1;
   assign cfg_bad = (i_nsym < IDX_W'(4)) || (i_nsym > IDX_W'(SLOT_SYMS)) ||
                    (span > (IDX_W+1)'(SLOT_SYMS)) || (IDX_W'(i_occi) >= min_nsf);
`else
   assign cfg_bad = 1'b0;
`endif

   assign k_inc = k_q + 1'b1;

   // next-state: config latch, hop bookkeeping, phi capture and descriptor handshake
   always_comb begin
      state_d  = state_q;
      n_d      = n_q;
      s_d      = s_q;
      k_d      = k_q;
      end_d    = end_q;
      hop_en_d = hop_en_q;
      hop_d    = hop_q;
      occi_d   = occi_q;
      nsf_d    = nsf_q;
      left_d   = left_q;
      phi_d    = phi_q;
      have_d   = have_q;
      next_d   = 1'b0;
      err_d    = 1'b0;
      if (state_q != IDLE && !have_q && i_spr_valid) begin
         phi_d  = i_spr_phi;
         have_d = 1'b1;
      end
      case (state_q)
         IDLE: begin
            have_d = 1'b0;
            if (i_start) begin
               if (cfg_bad) err_d = 1'b1;
               else begin
                  n_d      = i_nsym;
                  s_d      = i_start_sym;
                  hop_en_d = i_hop_en;
                  occi_d   = i_occi;
                  hop_d    = 1'b0;
                  k_d      = '0;
                  end_d    = i_hop_en ? i_nsym >> 1 : i_nsym;
                  nsf_d    = 3'(i_hop_en ? i_nsym >> 2 : i_nsym >> 1);
                  state_d  = HOP_INIT;
               end
            end
         end
         HOP_INIT: begin
            have_d  = 1'b0;
            left_d  = nsf_q;
            state_d = k_q[0] ? SPR_WAIT : EMIT;
         end
         SPR_WAIT: state_d = (have_q || i_spr_valid) ? EMIT : SPR_WAIT;
         EMIT: begin
            if (i_sym_ready) begin
               k_d = k_inc;
               if (k_q[0]) begin
                  have_d = 1'b0;
                  left_d = left_q - 3'd1;
                  next_d = left_q > 3'd1;
               end
               if (k_inc == end_q) begin
                  if (hop_en_q && !hop_q) begin
                     hop_d   = 1'b1;
                     end_d   = n_q;
                     nsf_d   = 3'((n_q >> 1) - (n_q >> 2));
                     state_d = HOP_INIT;
                  end else state_d = FIN;
               end else state_d = (!k_inc[0] || have_d) ? EMIT : SPR_WAIT;
            end
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // state register with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         n_q      <= '0;
         s_q      <= '0;
         k_q      <= '0;
         end_q    <= '0;
         hop_en_q <= 1'b0;
         hop_q    <= 1'b0;
         occi_q   <= '0;
         nsf_q    <= '0;
         left_q   <= '0;
         phi_q    <= '0;
         have_q   <= 1'b0;
         next_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         n_q      <= n_d;
         s_q      <= s_d;
         k_q      <= k_d;
         end_q    <= end_d;
         hop_en_q <= hop_en_d;
         hop_q    <= hop_d;
         occi_q   <= occi_d;
         nsf_q    <= nsf_d;
         left_q   <= left_d;
         phi_q    <= phi_d;
         have_q   <= have_d;
         next_q   <= next_d;
         err_q    <= err_d;
      end
   end

   assign o_busy      = state_q != IDLE;
   assign o_done      = state_q == FIN;
   assign o_err       = err_q;
   assign o_spr_start = state_q == HOP_INIT;
   assign o_spr_next  = next_q;
   assign o_spr_nsf   = o_busy ? nsf_q : 3'd0;
   assign o_spr_occi  = o_busy ? occi_q : 3'd0;
   assign o_sym_valid = state_q == EMIT;
   assign o_sym_idx   = o_sym_valid ? s_q + k_q : '0;
   assign o_sym_dmrs  = o_sym_valid & ~k_q[0];
   assign o_sym_hop   = o_sym_valid & hop_q;
   assign o_sym_phi   = (o_sym_valid & k_q[0]) ? phi_q : 4'd0;
endmodule

// File: tb/tb_pucch1_sym_ctrl.sv
// tb_pucch1_sym_ctrl: self-checking bench with a spreader model and a descriptor reference model
module tb_pucch1_sym_ctrl;
   localparam int IDX_W = 4;
   logic clk = 1'b0, rst = 1'b1;
   logic i_start = 1'b0, i_hop_en = 1'b0, i_spr_valid = 1'b0, i_sym_ready = 1'b0;
   logic [IDX_W-1:0] i_nsym = '0, i_start_sym = '0;
   logic [2:0] i_occi = '0;
   logic [3:0] i_spr_phi = '0;
   logic o_spr_start, o_spr_next, o_sym_valid, o_sym_dmrs, o_sym_hop, o_busy, o_done, o_err;
   logic [2:0] o_spr_nsf, o_spr_occi;
   logic [IDX_W-1:0] o_sym_idx;
   logic [3:0] o_sym_phi;

   typedef struct {int idx; bit dmrs; bit hop; int phi;} desc_t;
   desc_t exp_q[$];
   int cmp_n = 0, bad_n = 0;
   int spr_cnt, spr_m, spr_starts, salt;
   int spr_nexts[2], spr_nsf_seen[2];

   always #5 clk = ~clk;

   pucch1_sym_ctrl #(.SLOT_SYMS(14), .IDX_W(IDX_W)) dut (
      .clk(clk), .rst(rst), .i_start(i_start), .i_nsym(i_nsym), .i_start_sym(i_start_sym),
      .i_hop_en(i_hop_en), .i_occi(i_occi), .o_spr_start(o_spr_start), .o_spr_next(o_spr_next),
      .o_spr_nsf(o_spr_nsf), .o_spr_occi(o_spr_occi), .i_spr_phi(i_spr_phi), .i_spr_valid(i_spr_valid),
      .o_sym_valid(o_sym_valid), .i_sym_ready(i_sym_ready), .o_sym_idx(o_sym_idx),
      .o_sym_dmrs(o_sym_dmrs), .o_sym_hop(o_sym_hop), .o_sym_phi(o_sym_phi),
      .o_busy(o_busy), .o_done(o_done), .o_err(o_err));

   // phase the spreader model returns for data symbol m of hop h
   function automatic int phi_f(int h, int m);
      return (salt + 5 * m + 7 * h) & 15;
   endfunction

   task automatic spr_reset();
      spr_cnt = 0; spr_m = 0; spr_starts = 0;
      spr_nexts[0] = 0; spr_nexts[1] = 0; spr_nsf_seen[0] = -1; spr_nsf_seen[1] = -1;
      i_spr_valid = 1'b0;
   endtask

   // spreader model: one valid pulse 1..3 cycles after each start/next
   task automatic spr_step();
      i_spr_valid = 1'b0;
      if (spr_cnt > 0) begin
         spr_cnt--;
         if (spr_cnt == 0) begin
            i_spr_valid = 1'b1;
            i_spr_phi = 4'(phi_f(spr_starts - 1, spr_m));
         end
      end
      if (o_spr_start) begin
         if (spr_starts < 2) spr_nsf_seen[spr_starts] = int'(o_spr_nsf);
         spr_starts++; spr_m = 0; spr_cnt = $urandom_range(1, 3);
      end else if (o_spr_next) begin
         cmp_n++;
         if (spr_starts == 0) begin
            bad_n++; $display("FAIL next_before_start: o_spr_next=1 with no prior o_spr_start");
         end else if (spr_starts <= 2) spr_nexts[spr_starts-1]++;
         spr_m++; spr_cnt = $urandom_range(1, 3);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
      spr_step();
   endtask

   task automatic check_idle(input string nm);
      logic [31:0] got;
      got = {o_spr_start, o_spr_next, o_spr_nsf, o_spr_occi, o_sym_valid, o_sym_idx,
             o_sym_dmrs, o_sym_hop, o_sym_phi, o_busy, o_done, o_err};
      cmp_n++;
      if (got !== 32'd0) begin
         bad_n++; $display("FAIL %s: outputs=%h required all zero", nm, got);
      end
   endtask

   // run one sequence; mode 0 ready=1, 1 random ready, 2 three-cycle stall per descriptor
   task automatic run_seq(input int n, input int s, input int he, input int oc, input int mode,
                          input int abort_after, input int glitch);
      int half, nh, md[2], nsf_h[2], accepted, stall;
      bit pend, fin;
      desc_t d, held;
      half = n / 2; nh = he ? 2 : 1;
      nsf_h[0] = he ? n / 4 : half; nsf_h[1] = half - n / 4;
      md[0] = 0; md[1] = 0;
      exp_q.delete();
      for (int k = 0; k < n; k++) begin
         d.idx = s + k; d.hop = bit'(he != 0 && k >= half); d.dmrs = (k % 2 == 0);
         d.phi = d.dmrs ? 0 : phi_f(int'(d.hop), md[d.hop]);
         if (!d.dmrs) md[d.hop]++;
         exp_q.push_back(d);
      end
      salt = $urandom_range(0, 15);
      for (int k = 0; k < n; k++) if (!exp_q[k].dmrs) exp_q[k].phi = phi_f(int'(exp_q[k].hop), 0) +
         (exp_q[k].phi - phi_f(int'(exp_q[k].hop), 0));
      md[0] = 0; md[1] = 0;
      foreach (exp_q[k]) if (!exp_q[k].dmrs) begin
         exp_q[k].phi = phi_f(int'(exp_q[k].hop), md[exp_q[k].hop]);
         md[exp_q[k].hop]++;
      end
      spr_reset();
      i_nsym = IDX_W'(n); i_start_sym = IDX_W'(s); i_hop_en = (he != 0); i_occi = 3'(oc);
      i_start = 1'b1; i_sym_ready = 1'b0;
      accepted = 0; stall = 0; pend = 0; fin = 0;
      for (int c = 0; c < 3000 && !fin; c++) begin
         cyc();
         i_start = (c == glitch);
         i_nsym = IDX_W'($urandom_range(4, 14)); i_start_sym = IDX_W'($urandom_range(0, 13));
         i_hop_en = 1'($urandom); i_occi = 3'($urandom);
         cmp_n++;
         if (o_busy !== 1'b1 || o_err !== 1'b0 || o_spr_occi !== 3'(oc)) begin
            bad_n++; $display("FAIL busy_occi: busy=%b err=%b occi=%0d required 1/0/%0d", o_busy, o_err, o_spr_occi, oc);
         end
         if (pend) begin
            cmp_n++;
            if (o_sym_valid !== 1'b1 || int'(o_sym_idx) != held.idx || o_sym_dmrs !== held.dmrs ||
                o_sym_hop !== held.hop || int'(o_sym_phi) != held.phi) begin
               bad_n++; $display("FAIL stable: valid=%b idx=%0d held idx=%0d", o_sym_valid, o_sym_idx, held.idx);
            end
         end
         if (o_done) begin
            fin = 1;
            cmp_n++;
            if (exp_q.size() != 0 || spr_starts != nh) begin
               bad_n++; $display("FAIL done_count: left=%0d starts=%0d required 0/%0d", exp_q.size(), spr_starts, nh);
            end
            for (int h = 0; h < nh; h++) begin
               cmp_n++;
               if (spr_nexts[h] != nsf_h[h] - 1 || spr_nsf_seen[h] != nsf_h[h]) begin
                  bad_n++; $display("FAIL hop%0d_spr: nexts=%0d nsf=%0d required %0d/%0d", h, spr_nexts[h], spr_nsf_seen[h], nsf_h[h] - 1, nsf_h[h]);
               end
            end
            i_sym_ready = 1'b0;
            cyc();
            cmp_n++;
            if (o_busy !== 1'b0 || o_done !== 1'b0) begin
               bad_n++; $display("FAIL after_done: busy=%b done=%b required 0/0", o_busy, o_done);
            end
         end else if (o_sym_valid) begin
            i_sym_ready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom) : (stall >= 3);
            stall = i_sym_ready ? 0 : stall + 1;
            held.idx = int'(o_sym_idx); held.dmrs = o_sym_dmrs; held.hop = o_sym_hop; held.phi = int'(o_sym_phi);
            pend = !i_sym_ready;
            if (i_sym_ready) begin
               cmp_n++;
               if (exp_q.size() == 0) begin
                  bad_n++; $display("FAIL extra_desc: idx=%0d required none", o_sym_idx);
               end else begin
                  d = exp_q.pop_front();
                  if (d.idx != held.idx || d.dmrs != held.dmrs || d.hop != held.hop || d.phi != held.phi) begin
                     bad_n++;
                     $display("FAIL desc: idx=%0d dmrs=%0d hop=%0d phi=%0d required %0d/%0d/%0d/%0d",
                              held.idx, held.dmrs, held.hop, held.phi, d.idx, d.dmrs, d.hop, d.phi);
                  end
               end
               accepted++;
               if (accepted == abort_after) return;
            end
         end else i_sym_ready = (mode == 1) ? 1'($urandom) : 1'b1;
      end
      if (!fin) begin
         cmp_n++; bad_n++; $display("FAIL timeout: no o_done within budget");
      end
      i_start = 1'b0; i_sym_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; cyc(); cyc(); rst = 1'b0;
      check_idle("reset");
      cyc(); check_idle("reset_idle");
   endtask

   task automatic test_basic();
      run_seq(4, 0, 0, 1, 0, -1, -1);
      run_seq(10, 2, 1, 1, 0, -1, -1);
   endtask

   task automatic test_stall();
      run_seq(4, 0, 0, 1, 2, -1, -1);
      run_seq(10, 2, 1, 1, 1, -1, -1);
   endtask

   task automatic test_reset_mid();
      run_seq(10, 2, 1, 1, 0, 4, -1);
      i_start = 1'b0; rst = 1'b1;
      cyc(); check_idle("reset_mid");
      rst = 1'b0; i_sym_ready = 1'b0;
      cyc(); check_idle("reset_mid_idle");
      run_seq(10, 2, 1, 1, 0, -1, -1);
   endtask

   task automatic test_start_while_busy();
      run_seq(10, 2, 1, 1, 0, -1, 3);
      run_seq(10, 2, 1, 1, 1, -1, 7);
   endtask

   task automatic test_random();
      int n, s, he, mn;
      for (int t = 0; t < 25; t++) begin
         n = $urandom_range(4, 14); s = $urandom_range(0, 14 - n); he = $urandom_range(0, 1);
         mn = he ? n / 4 : n / 2;
         run_seq(n, s, he, $urandom_range(0, mn - 1), $urandom_range(0, 2), -1, $urandom_range(0, 6));
         repeat ($urandom_range(0, 2)) cyc();
      end
   endtask

`ifdef PUCCH1_CTRL_CHECK_EN
   task automatic test_err();
      int errs, starts, busy;
      int cfg_n[3] = '{4, 3, 8};
      int cfg_s[3] = '{12, 0, 0};
      int cfg_o[3] = '{0, 0, 2};
      for (int t = 0; t < 3; t++) begin
         spr_reset();
         i_nsym = IDX_W'(cfg_n[t]); i_start_sym = IDX_W'(cfg_s[t]); i_hop_en = 1'b1; i_occi = 3'(cfg_o[t]);
         i_start = 1'b1; errs = 0; starts = 0; busy = 0;
         for (int c = 0; c < 6; c++) begin
            cyc(); i_start = 1'b0;
            errs += int'(o_err); starts += int'(o_spr_start); busy += int'(o_busy | o_sym_valid | o_done);
         end
         cmp_n++;
         if (errs != 1 || starts != 0 || busy != 0) begin
            bad_n++; $display("FAIL cfg_err%0d: err=%0d starts=%0d busy=%0d required 1/0/0", t, errs, starts, busy);
         end
      end
   endtask
`endif

   initial begin
      spr_reset();
      test_reset();
      test_basic();
      test_stall();
      test_reset_mid();
      test_start_while_busy();
      test_random();
`ifdef PUCCH1_CTRL_CHECK_EN
      test_err();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, bad_n);
      $finish;
   end
endmodule
